// File: rtl/mem_responder.sv
// Single-port memory target for the matrix-multiply request interface: in-order
// read responses after RD_LAT cycles, a side load port, access counters and sticky error flags.
module mem_responder #(
    parameter int          MEM_AW = 16,
    parameter int          MEM_DW = 32,
    parameter int          RAM_AW = 10,
    parameter int unsigned BASE   = 0,
    parameter int          RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [MEM_DW-1:0] mem_wdata,
    output logic              mem_rdata_vld,
    output logic [MEM_DW-1:0] mem_rdata,
    input  logic              ld_we,
    input  logic [RAM_AW-1:0] ld_addr,
    input  logic [MEM_DW-1:0] ld_wdata,
    input  logic              clr,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt,
    output logic [1:0]        err
);

    localparam int              RAM_WORDS = 1 << RAM_AW;
    localparam logic [MEM_AW:0] BASE_X    = {1'b0, MEM_AW'(BASE)};

    logic [MEM_DW-1:0] mem_array_r [RAM_WORDS];
    logic              vld_pipe_r  [RD_LAT];
    logic [MEM_DW-1:0] data_pipe_r [RD_LAT];

    logic [MEM_AW:0]   diff_s;
    logic [RAM_AW-1:0] idx_s;
    logic              in_range_s;
    logic              rd_req_s;
    logic              wr_req_s;
    logic              wr_ok_s;
    logic              ld_ok_s;
    logic              oor_s;
    logic              coll_s;

    // Request decode; the borrow bit of the widened subtraction flags mem_addr < BASE
    always_comb begin
        diff_s     = {1'b0, mem_addr} - BASE_X;
        idx_s      = diff_s[RAM_AW-1:0];
        in_range_s = !diff_s[MEM_AW] && (diff_s[MEM_AW-1:RAM_AW] == '0);
        rd_req_s   = mem_req && !mem_write;
        wr_req_s   = mem_req && mem_write;
        wr_ok_s    = wr_req_s && in_range_s;
        ld_ok_s    = ld_we && !mem_req;
        oor_s      = mem_req && !in_range_s;
        coll_s     = mem_req && ld_we;
    end

    // Array write port: request writes win, a load write only lands on an idle request cycle
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_array_r[idx_s] <= mem_wdata;
        end else if (ld_ok_s) begin
            mem_array_r[ld_addr] <= ld_wdata;
        end
    end

    // Read pipeline: stage 0 is the synchronous array read, data held at zero whenever not valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_pipe_r[i]  <= 1'b0;
                data_pipe_r[i] <= '0;
            end
        end else begin
            vld_pipe_r[0]  <= rd_req_s;
            data_pipe_r[0] <= (rd_req_s && in_range_s) ? mem_array_r[idx_s] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_r[i]  <= vld_pipe_r[i-1];
                data_pipe_r[i] <= data_pipe_r[i-1];
            end
        end
    end

    assign mem_rdata_vld = vld_pipe_r[RD_LAT-1];
    assign mem_rdata     = data_pipe_r[RD_LAT-1];

    // Access counters and sticky error flags; clr overrides anything accepted on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= 32'd0;
            wr_cnt <= 32'd0;
            err    <= 2'b00;
        end else if (clr) begin
            rd_cnt <= 32'd0;
            wr_cnt <= 32'd0;
            err    <= 2'b00;
        end else begin
            if (rd_req_s) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (wr_req_s) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
            err <= err | {coll_s, oor_s};
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (RD_LAT 2, 1, 4) share one stimulus stream
// and are compared every cycle against a queue-based model of the memory and its responses.
module tb_mem_responder;

    localparam int          AW      = 16;
    localparam int          DW      = 32;
    localparam int          RAW     = 10;
    localparam int unsigned TB_BASE = 0;
    localparam int          WORDS   = 1 << RAW;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           mem_req = 1'b0;
    logic           mem_write = 1'b0;
    logic [AW-1:0]  mem_addr = '0;
    logic [DW-1:0]  mem_wdata = '0;
    logic           ld_we = 1'b0;
    logic [RAW-1:0] ld_addr = '0;
    logic [DW-1:0]  ld_wdata = '0;
    logic           clr = 1'b0;

    logic          vld_o   [3];
    logic [DW-1:0] rdata_o [3];
    logic [31:0]   rdc_o   [3];
    logic [31:0]   wrc_o   [3];
    logic [1:0]    err_o   [3];

    always #5 clk = ~clk;

    mem_responder #(.MEM_AW(AW), .MEM_DW(DW), .RAM_AW(RAW), .BASE(TB_BASE), .RD_LAT(2)) u_l2 (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata_vld(vld_o[0]), .mem_rdata(rdata_o[0]), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .clr(clr), .rd_cnt(rdc_o[0]), .wr_cnt(wrc_o[0]),
        .err(err_o[0]));
    mem_responder #(.MEM_AW(AW), .MEM_DW(DW), .RAM_AW(RAW), .BASE(TB_BASE), .RD_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata_vld(vld_o[1]), .mem_rdata(rdata_o[1]), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .clr(clr), .rd_cnt(rdc_o[1]), .wr_cnt(wrc_o[1]),
        .err(err_o[1]));
    mem_responder #(.MEM_AW(AW), .MEM_DW(DW), .RAM_AW(RAW), .BASE(TB_BASE), .RD_LAT(4)) u_l4 (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata_vld(vld_o[2]), .mem_rdata(rdata_o[2]), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .clr(clr), .rd_cnt(rdc_o[2]), .wr_cnt(wrc_o[2]),
        .err(err_o[2]));

    typedef struct {
        int unsigned due;
        logic [DW-1:0] data;
    } resp_t;

    int          lat_c [3];
    logic [DW-1:0] ref_mem [WORDS];
    resp_t       rq [3][$];
    int unsigned m_rd;
    int unsigned m_wr;
    logic [1:0]  m_err;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic drive_idle();
        mem_req = 1'b0; mem_write = 1'b0; ld_we = 1'b0; clr = 1'b0;
    endtask

    task automatic drive_req(input logic wr, input int unsigned addr, input logic [DW-1:0] wd);
        mem_req = 1'b1; mem_write = wr; mem_addr = AW'(addr); mem_wdata = wd;
        ld_we = 1'b0; clr = 1'b0;
    endtask

    // One clock: update the model at the rising edge, compare every instance at the falling edge
    task automatic tick();
        int unsigned a;
        int unsigned off;
        logic        inr;
        resp_t       r;
        logic        exp_v;
        logic [DW-1:0] exp_d;
        @(posedge clk);
        cyc++;
        if (rst) begin
            for (int i = 0; i < 3; i++) rq[i].delete();
            m_rd = 0; m_wr = 0; m_err = 2'b00;
        end else begin
            if (mem_req) begin
                a   = int'(mem_addr);
                inr = (a >= TB_BASE) && (a - TB_BASE < WORDS);
                off = inr ? a - TB_BASE : 0;
                if (mem_write) begin
                    if (inr) ref_mem[off] = mem_wdata;
                    else m_err[0] = 1'b1;
                    m_wr++;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        r.due  = cyc + lat_c[i] - 1;
                        r.data = inr ? ref_mem[off] : 32'h0;
                        rq[i].push_back(r);
                    end
                    if (!inr) m_err[0] = 1'b1;
                    m_rd++;
                end
                if (ld_we) m_err[1] = 1'b1;
            end else if (ld_we) begin
                ref_mem[ld_addr] = ld_wdata;
            end
            if (clr) begin
                m_rd = 0; m_wr = 0; m_err = 2'b00;
            end
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            exp_v = 1'b0;
            exp_d = 32'h0;
            if (rq[i].size() > 0 && rq[i][0].due == cyc) begin
                exp_v = 1'b1;
                exp_d = rq[i][0].data;
                void'(rq[i].pop_front());
            end
            n_chk++;
            if (vld_o[i] !== exp_v || rdata_o[i] !== exp_d) begin
                n_fail++;
                $display("FAIL resp_lat%0d cyc %0d: got vld=%b data=%h, expected vld=%b data=%h",
                         lat_c[i], cyc, vld_o[i], rdata_o[i], exp_v, exp_d);
            end
            n_chk++;
            if (rdc_o[i] !== m_rd || wrc_o[i] !== m_wr || err_o[i] !== m_err) begin
                n_fail++;
                $display("FAIL status_lat%0d cyc %0d: got rd=%0d wr=%0d err=%b, expected rd=%0d wr=%0d err=%b",
                         lat_c[i], cyc, rdc_o[i], wrc_o[i], err_o[i], m_rd, m_wr, m_err);
            end
        end
    endtask

    // Idle until the RD_LAT=2 instance answers; k=0 means nothing arrived within the budget
    task automatic collect(input int maxc, output int k, output logic [DW-1:0] d);
        drive_idle();
        k = 0;
        d = '0;
        for (int j = 1; j <= maxc && k == 0; j++) begin
            tick();
            if (vld_o[0] === 1'b1) begin
                k = j;
                d = rdata_o[0];
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) rq[i].delete();
        m_rd = 0; m_wr = 0; m_err = 2'b00;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (vld_o[i] !== 1'b0 || rdata_o[i] !== 32'h0 || rdc_o[i] !== 32'h0 ||
                wrc_o[i] !== 32'h0 || err_o[i] !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_state lat%0d: got vld=%b data=%h rd=%0d wr=%0d err=%b, expected all zero",
                         lat_c[i], vld_o[i], rdata_o[i], rdc_o[i], wrc_o[i], err_o[i]);
            end
        end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_preload();
        for (int k = 0; k < WORDS; k++) begin
            ld_we = 1'b1; ld_addr = RAW'(k); ld_wdata = $urandom;
            tick();
        end
        drive_idle();
    endtask

    task automatic test_burst_read();
        int first_k;
        int last_k;
        logic [DW-1:0] got [$];
        for (int k = 0; k < 4; k++) begin
            ld_we = 1'b1; ld_addr = RAW'(k); ld_wdata = DW'(k + 1);
            tick();
        end
        drive_idle(); clr = 1'b1;
        tick();
        first_k = 0; last_k = 0;
        for (int k = 1; k <= 9; k++) begin
            if (k <= 4) drive_req(1'b0, TB_BASE + k - 1, '0);
            else drive_idle();
            tick();
            if (vld_o[0] === 1'b1) begin
                if (first_k == 0) first_k = k;
                last_k = k;
                got.push_back(rdata_o[0]);
            end
        end
        n_chk++;
        if (first_k !== 2 || last_k !== 5 || got.size() !== 4) begin
            n_fail++;
            $display("FAIL burst_timing: got first=%0d last=%0d count=%0d, expected first=2 last=5 count=4",
                     first_k, last_k, got.size());
        end
        for (int j = 0; j < got.size(); j++) begin
            n_chk++;
            if (got[j] !== DW'(j + 1)) begin
                n_fail++;
                $display("FAIL burst_data[%0d]: got %h, expected %h", j, got[j], DW'(j + 1));
            end
        end
        n_chk++;
        if (rdc_o[0] !== 32'd4) begin
            n_fail++;
            $display("FAIL burst_rd_cnt: got %0d, expected 4", rdc_o[0]);
        end
    endtask

    task automatic test_raw();
        int k;
        logic [DW-1:0] d;
        drive_idle(); clr = 1'b1;
        tick();
        drive_req(1'b1, TB_BASE + 5, 32'hDEADBEEF);
        tick();
        drive_req(1'b0, TB_BASE + 5, '0);
        tick();
        collect(6, k, d);
        n_chk++;
        if (k !== 1 || d !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL raw_data: got k=%0d data=%h, expected k=1 data=deadbeef", k, d);
        end
        n_chk++;
        if (wrc_o[0] !== 32'd1 || rdc_o[0] !== 32'd1 || err_o[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL raw_status: got wr=%0d rd=%0d err=%b, expected wr=1 rd=1 err=00",
                     wrc_o[0], rdc_o[0], err_o[0]);
        end
    endtask

    task automatic test_out_of_range();
        int k;
        logic [DW-1:0] d;
        logic [DW-1:0] keep;
        keep = ref_mem[0];
        drive_idle(); clr = 1'b1;
        tick();
        drive_req(1'b1, TB_BASE + WORDS, 32'h12345678);
        tick();
        drive_req(1'b0, TB_BASE + WORDS, '0);
        tick();
        collect(6, k, d);
        n_chk++;
        if (k !== 1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_read: got k=%0d data=%h, expected k=1 data=0", k, d);
        end
        n_chk++;
        if (err_o[0] !== 2'b01 || rdc_o[0] !== 32'd1 || wrc_o[0] !== 32'd1) begin
            n_fail++;
            $display("FAIL oor_status: got err=%b rd=%0d wr=%0d, expected err=01 rd=1 wr=1",
                     err_o[0], rdc_o[0], wrc_o[0]);
        end
        drive_req(1'b0, TB_BASE, '0);
        tick();
        collect(6, k, d);
        n_chk++;
        if (d !== keep) begin
            n_fail++;
            $display("FAIL oor_no_alias: got %h, expected %h", d, keep);
        end
    endtask

    task automatic test_collision();
        int k;
        logic [DW-1:0] d;
        ld_we = 1'b1; ld_addr = RAW'(7); ld_wdata = 32'h0;
        tick();
        drive_idle(); clr = 1'b1;
        tick();
        drive_req(1'b0, TB_BASE + 7, '0);
        ld_we = 1'b1; ld_addr = RAW'(7); ld_wdata = 32'd9;
        tick();
        collect(6, k, d);
        n_chk++;
        if (k !== 1 || d !== 32'h0 || err_o[0] !== 2'b10) begin
            n_fail++;
            $display("FAIL collision: got k=%0d data=%h err=%b, expected k=1 data=0 err=10", k, d, err_o[0]);
        end
        drive_req(1'b0, TB_BASE + 7, '0);
        tick();
        collect(6, k, d);
        n_chk++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL collision_dropped: array[7] got %h, expected 0", d);
        end
    endtask

    task automatic test_reset_flush();
        int seen;
        int k;
        logic [DW-1:0] d;
        for (int j = 0; j < 3; j++) begin
            drive_req(1'b0, TB_BASE + j, '0);
            tick();
        end
        drive_idle();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        seen = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            for (int i = 0; i < 3; i++) if (vld_o[i] === 1'b1) seen++;
        end
        n_chk++;
        if (seen !== 0 || rdc_o[0] !== 32'd0 || wrc_o[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL flush: got stray=%0d rd=%0d wr=%0d, expected 0 0 0", seen, rdc_o[0], wrc_o[0]);
        end
        drive_req(1'b0, TB_BASE + 2, '0);
        tick();
        collect(6, k, d);
        n_chk++;
        if (k !== 1 || d !== ref_mem[2]) begin
            n_fail++;
            $display("FAIL post_reset_read: got k=%0d data=%h, expected k=1 data=%h", k, d, ref_mem[2]);
        end
    endtask

    task automatic test_clr();
        int seen;
        drive_req(1'b0, TB_BASE + 3, '0);
        tick();
        drive_req(1'b0, TB_BASE + 2000, '0);
        clr = 1'b1;
        tick();
        seen = (vld_o[0] === 1'b1) ? 1 : 0;
        n_chk++;
        if (rdc_o[0] !== 32'd0 || err_o[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL clr_wins: got rd=%0d err=%b, expected rd=0 err=00", rdc_o[0], err_o[0]);
        end
        drive_idle();
        for (int j = 0; j < 5; j++) begin
            tick();
            if (vld_o[0] === 1'b1) seen++;
        end
        n_chk++;
        if (seen !== 2 || rdc_o[0] !== 32'd0 || err_o[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL clr_inflight: got responses=%0d rd=%0d err=%b, expected 2 0 00",
                     seen, rdc_o[0], err_o[0]);
        end
    endtask

    task automatic test_latency();
        int first_k [3];
        drive_idle();
        repeat (5) tick();
        for (int i = 0; i < 3; i++) first_k[i] = 0;
        drive_req(1'b0, TB_BASE + 1, '0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            drive_idle();
            for (int i = 0; i < 3; i++) if (vld_o[i] === 1'b1 && first_k[i] == 0) first_k[i] = k;
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (first_k[i] !== lat_c[i]) begin
                n_fail++;
                $display("FAIL latency_lat%0d: got %0d cycles, expected %0d", lat_c[i], first_k[i], lat_c[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 500; j++) begin
            mem_req   = ($urandom_range(0, 3) != 0);
            mem_write = $urandom_range(0, 1) == 1;
            mem_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(WORDS, 65535))
                                                   : AW'($urandom_range(0, WORDS - 1));
            mem_wdata = $urandom;
            ld_we     = ($urandom_range(0, 4) == 0);
            ld_addr   = RAW'($urandom_range(0, WORDS - 1));
            ld_wdata  = $urandom;
            clr       = ($urandom_range(0, 39) == 0);
            tick();
        end
        drive_idle();
        repeat (6) tick();
    endtask

    initial begin
        lat_c = '{2, 1, 4};
        m_rd = 0; m_wr = 0; m_err = 2'b00;
        test_reset();
        test_preload();
        test_burst_read();
        test_raw();
        test_out_of_range();
        test_collision();
        test_reset_flush();
        test_clr();
        test_latency();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
